map_table_ckpt: RTL

Parametrised register-rename map table: the next generation of the two-wide map table in this pipeline. It renames up to DISPATCH_W instructions per cycle with full intra-group dependency bypass and wakes ready bits by physical-tag CAM on up to CDB_W broadcast channels. It adds NUM_CKPT branch checkpoints for single-cycle mispredict recovery, plus a full flush from the retirement map. It sits between decode/free-list and the RS/ROB at dispatch.

---
 rtl/map_table_ckpt.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/map_table_ckpt.sv
// rtl/map_table_ckpt.sv - register rename map table with branch checkpoints and CDB wakeup
module map_table_ckpt #(
    parameter int NUM_AR       = 32,
    parameter int PR_W         = 7,
    parameter int DISPATCH_W   = 2,
    parameter int CDB_W        = 6,
    parameter int NUM_CKPT     = 4,
    localparam int AR_W        = $clog2(NUM_AR),
    localparam int CK_W        = (NUM_CKPT > 1) ? $clog2(NUM_CKPT) : 1
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [DISPATCH_W-1:0]        disp_valid,
    input  logic [DISPATCH_W-1:0]        disp_wr,
    input  logic [DISPATCH_W*AR_W-1:0]   disp_dest,
    input  logic [DISPATCH_W*PR_W-1:0]   disp_newpr,
    input  logic [DISPATCH_W*AR_W-1:0]   disp_ra,
    input  logic [DISPATCH_W*AR_W-1:0]   disp_rb,
    output logic [DISPATCH_W*PR_W-1:0]   rs_pra,
    output logic [DISPATCH_W*PR_W-1:0]   rs_prb,
    output logic [DISPATCH_W-1:0]        rs_pra_rdy,
    output logic [DISPATCH_W-1:0]        rs_prb_rdy,
    output logic [DISPATCH_W*PR_W-1:0]   rob_told,
    input  logic [CDB_W-1:0]             cdb_valid,
    input  logic [CDB_W*PR_W-1:0]        cdb_pr,
    input  logic                         ckpt_take,
    output logic [CK_W-1:0]              ckpt_id,
    output logic                         ckpt_full,
    input  logic                         ckpt_release,
    input  logic [CK_W-1:0]              ckpt_release_id,
    input  logic                         recover,
    input  logic [CK_W-1:0]              recover_id,
    input  logic [NUM_CKPT-1:0]          recover_free_mask,
    input  logic                         flush,
    input  logic [NUM_AR*PR_W-1:0]       arch_map
);

    logic [PR_W-1:0]   map_q     [NUM_AR];
    logic [NUM_AR-1:0] rdy_q;
    logic [PR_W-1:0]   map_nx    [NUM_AR];
    logic [NUM_AR-1:0] rdy_nx;
    logic [NUM_AR-1:0] map_hit;

    logic [PR_W-1:0]   ckpt_tags [NUM_CKPT][NUM_AR];
    logic [NUM_AR-1:0] ckpt_rdy  [NUM_CKPT];
    logic [NUM_AR-1:0] ckpt_hit  [NUM_CKPT];
    logic [NUM_CKPT-1:0] ckpt_alloc;
    logic [NUM_CKPT-1:0] alloc_nx;

    logic take_ok;

    // CAM match of one tag against every valid broadcast channel
    function automatic logic cdb_hit(input logic [PR_W-1:0] tag);
        logic hit;
        hit = 1'b0;
        for (int c = 0; c < CDB_W; c++) begin
            if (cdb_valid[c] && (cdb_pr[c*PR_W +: PR_W] == tag)) begin
                hit = 1'b1;
            end
        end
        return hit;
    endfunction

    // Wakeup match for every live map entry and every checkpoint entry
    always_comb begin
        for (int e = 0; e < NUM_AR; e++) begin
            map_hit[e] = cdb_hit(map_q[e]);
        end
        for (int k = 0; k < NUM_CKPT; k++) begin
            for (int e = 0; e < NUM_AR; e++) begin
                ckpt_hit[k][e] = cdb_hit(ckpt_tags[k][e]);
            end
        end
    end

    // Source and previous-dest lookup with bypass from older slots in the group
    always_comb begin
        logic [AR_W-1:0] sa, sb, sd;
        logic [PR_W-1:0] ta, tb, td, np;
        logic            ra, rb;
        rs_pra     = '0;
        rs_prb     = '0;
        rs_pra_rdy = '0;
        rs_prb_rdy = '0;
        rob_told   = '0;
        for (int j = 0; j < DISPATCH_W; j++) begin
            sa = disp_ra[j*AR_W +: AR_W];
            sb = disp_rb[j*AR_W +: AR_W];
            sd = disp_dest[j*AR_W +: AR_W];
            ta = map_q[sa];
            tb = map_q[sb];
            td = map_q[sd];
            ra = rdy_q[sa] | map_hit[sa];
            rb = rdy_q[sb] | map_hit[sb];
            // later (younger) older-slot matches overwrite earlier ones
            for (int i = 0; i < j; i++) begin
                np = disp_newpr[i*PR_W +: PR_W];
                if (disp_valid[i] && disp_wr[i]) begin
                    if (disp_dest[i*AR_W +: AR_W] == sa) begin
                        ta = np;
                        ra = 1'b0;
                    end
                    if (disp_dest[i*AR_W +: AR_W] == sb) begin
                        tb = np;
                        rb = 1'b0;
                    end
                    if (disp_dest[i*AR_W +: AR_W] == sd) begin
                        td = np;
                    end
                end
            end
            rs_pra[j*PR_W +: PR_W] = ta;
            rs_prb[j*PR_W +: PR_W] = tb;
            rs_pra_rdy[j]          = ra;
            rs_prb_rdy[j]          = rb;
            rob_told[j*PR_W +: PR_W] = td;
        end
    end

    // Post-dispatch, post-wakeup map; youngest writer wins and dispatch beats wakeup
    always_comb begin
        for (int e = 0; e < NUM_AR; e++) begin
            map_nx[e] = map_q[e];
        end
        rdy_nx = rdy_q | map_hit;
        for (int k = 0; k < DISPATCH_W; k++) begin
            if (disp_valid[k] && disp_wr[k]) begin
                map_nx[disp_dest[k*AR_W +: AR_W]] = disp_newpr[k*PR_W +: PR_W];
                rdy_nx[disp_dest[k*AR_W +: AR_W]] = 1'b0;
            end
        end
    end

    // Lowest free checkpoint slot, 0 when none is free
    always_comb begin
        ckpt_id = '0;
        for (int k = NUM_CKPT - 1; k >= 0; k--) begin
            if (!ckpt_alloc[k]) begin
                ckpt_id = CK_W'(k);
            end
        end
    end

    assign ckpt_full = &ckpt_alloc;
    assign take_ok   = ckpt_take && !ckpt_full && !flush && !recover;

    // Next allocation vector: flush clears all, recover frees the mask, else release/take
    always_comb begin
        alloc_nx = ckpt_alloc;
        if (flush) begin
            alloc_nx = '0;
        end else if (recover) begin
            alloc_nx = ckpt_alloc & ~recover_free_mask;
        end else begin
            if (ckpt_release) begin
                alloc_nx[ckpt_release_id] = 1'b0;
            end
            if (take_ok) begin
                alloc_nx[ckpt_id] = 1'b1;
            end
        end
    end

    // Live map state: reset > flush > recover > normal rename/wakeup
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int e = 0; e < NUM_AR; e++) begin
                map_q[e] <= PR_W'(e);
            end
            rdy_q <= '1;
        end else if (flush) begin
            for (int e = 0; e < NUM_AR; e++) begin
                map_q[e] <= arch_map[e*PR_W +: PR_W];
            end
            rdy_q <= '1;
        end else if (recover) begin
            map_q <= ckpt_tags[recover_id];
            rdy_q <= ckpt_rdy[recover_id] | ckpt_hit[recover_id];
        end else begin
            map_q <= map_nx;
            rdy_q <= rdy_nx;
        end
    end

    // Checkpoint allocation bits
    always_ff @(posedge clock) begin
        if (reset) begin
            ckpt_alloc <= '0;
        end else begin
            ckpt_alloc <= alloc_nx;
        end
    end

    // Checkpoint contents: snoop wakeups every cycle, overwrite the taken slot
    always_ff @(posedge clock) begin
        for (int k = 0; k < NUM_CKPT; k++) begin
            ckpt_rdy[k] <= ckpt_rdy[k] | ckpt_hit[k];
        end
        if (!reset && take_ok) begin
            ckpt_tags[ckpt_id] <= map_nx;
            ckpt_rdy[ckpt_id]  <= rdy_nx;
        end
    end

endmodule
